// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dma_pkg
//  Description : Shared DMA types and constants: descriptor and error
//                structs, error-source codes, read-streamer state encoding.
//  Revision    : 1.0 - initial release with read streamer support
// ============================================================================
package dma_pkg;

    localparam int DMA_ADDR_W      = 32;
    localparam int DMA_BYTES_W     = 32;
    localparam int DMA_4K_BOUNDARY = 4096;

    // Originator codes carried in the error struct's src field
    localparam logic DMA_ERR_SRC_WR = 1'b0;
    localparam logic DMA_ERR_SRC_RD = 1'b1;

    typedef struct packed {
        logic [DMA_ADDR_W-1:0]  src_addr;
        logic [DMA_ADDR_W-1:0]  dst_addr;
        logic [DMA_BYTES_W-1:0] num_bytes;
    } s_dma_desc_t;

    typedef struct packed {
        logic                  valid;
        logic                  src;
        logic [DMA_ADDR_W-1:0] addr;
    } s_dma_error_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_REQ  = 2'd2,
        ST_DONE = 2'd3
    } rd_strm_st_t;

endpackage
`default_nettype wire

// File: rtl/dma_burst_calc.sv
`default_nettype none
// ============================================================================
//  Module      : dma_burst_calc
//  Description : Combinational burst sizer. Picks the largest burst that
//                fits the remaining beats, the MAX_BEATS cap and the space
//                left before the next 4 KB page, returned as AXI len (beats-1).
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BEATS_W   = 29,
    parameter int MAX_BEATS = 16,
    parameter int BPB_LOG2  = 3
) (
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [BEATS_W-1:0] beats_i,
    output logic [7:0]         len_o
);

    localparam int PAGE_LOG2 = $clog2(DMA_4K_BOUNDARY);
    // Beat count to the page end can equal a whole page (addr at offset 0)
    localparam int REM_W     = PAGE_LOG2 - BPB_LOG2 + 1;
    localparam int CMP_W     = (BEATS_W > 16) ? BEATS_W : 16;

    logic [REM_W-1:0] rem_beats;
    logic [CMP_W-1:0] burst;

    // Beats left before the page boundary (addresses are beat aligned)
    assign rem_beats = REM_W'(1 << (PAGE_LOG2 - BPB_LOG2))
                     - REM_W'(addr_i[PAGE_LOG2-1:BPB_LOG2]);

    // Three-way minimum, then convert the beat count to AXI len encoding
    always_comb begin
        burst = CMP_W'(beats_i);
        if (CMP_W'(MAX_BEATS) < burst) begin
            burst = CMP_W'(MAX_BEATS);
        end
        if (CMP_W'(rem_beats) < burst) begin
            burst = CMP_W'(rem_beats);
        end
        len_o = 8'(burst - CMP_W'(1));
    end

endmodule
`default_nettype wire

// File: rtl/dma_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : dma_rd_streamer
//  Description : Read-side DMA streamer. Accepts a descriptor from the DMA
//                FSM, splits its source region into AXI4 INCR read-burst
//                requests (MAX_BEATS and 4 KB limited), pulses done when all
//                requests are issued and flags misaligned descriptors.
//  Revision    : 1.0 - initial release
// ============================================================================
module dma_rd_streamer
    import dma_pkg::*;
#(
    parameter int ADDR_W    = DMA_ADDR_W,
    parameter int DATA_W    = 64,
    parameter int BYTES_W   = DMA_BYTES_W,
    parameter int MAX_BEATS = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              dma_stream_rd_valid_i,
    input  s_dma_desc_t       dma_desc_i,
    input  logic              clear_dma_i,
    output logic              dma_stream_rd_done_o,
    output s_dma_error_t      dma_stream_rd_err_o,
    output logic              rd_req_valid_o,
    input  logic              rd_req_ready_i,
    output logic [ADDR_W-1:0] rd_req_addr_o,
    output logic [7:0]        rd_req_len_o,
    output logic [2:0]        rd_req_size_o,
    output logic              rd_busy_o
);

    localparam int BPB      = DATA_W / 8;
    localparam int BPB_LOG2 = $clog2(BPB);
    localparam int BEATS_W  = BYTES_W - BPB_LOG2;

    rd_strm_st_t        state_q, state_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [BEATS_W-1:0] beats_q, beats_d;
    logic [7:0]         len_q,   len_d;
    logic               done_q,  done_d;

    logic [7:0]         calc_len;
    logic [8:0]         burst_beats;
    logic [BEATS_W-1:0] beats_left;
    logic               misaligned;

    dma_burst_calc #(
        .ADDR_W    (ADDR_W),
        .BEATS_W   (BEATS_W),
        .MAX_BEATS (MAX_BEATS),
        .BPB_LOG2  (BPB_LOG2)
    ) u_burst_calc (
        .addr_i  (addr_q),
        .beats_i (beats_q),
        .len_o   (calc_len)
    );

    assign burst_beats = {1'b0, len_q} + 9'd1;
    assign beats_left  = beats_q - BEATS_W'(burst_beats);
    assign misaligned  = (|dma_desc_i.src_addr[BPB_LOG2-1:0])
                       | (|dma_desc_i.num_bytes[BPB_LOG2-1:0]);

    // State, counters and the done pulse; async active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            beats_q <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            beats_q <= beats_d;
            len_q   <= len_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter update and request/error outputs
    always_comb begin
        state_d             = state_q;
        addr_d              = addr_q;
        beats_d             = beats_q;
        len_d               = len_q;
        done_d              = 1'b0;
        rd_req_valid_o      = 1'b0;
        dma_stream_rd_err_o = '0;

        case (state_q)
            ST_IDLE: begin
                if (dma_stream_rd_valid_i) begin
                    if (dma_desc_i.num_bytes == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else if (misaligned) begin
                        dma_stream_rd_err_o.valid = 1'b1;
                        dma_stream_rd_err_o.src   = DMA_ERR_SRC_RD;
                        dma_stream_rd_err_o.addr  = dma_desc_i.src_addr;
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = dma_desc_i.src_addr;
                        beats_d = BEATS_W'(dma_desc_i.num_bytes >> BPB_LOG2);
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                len_d   = calc_len;
                state_d = ST_REQ;
            end
            ST_REQ: begin
                rd_req_valid_o = 1'b1;
                if (rd_req_ready_i) begin
                    addr_d  = addr_q + (ADDR_W'(burst_beats) << BPB_LOG2);
                    beats_d = beats_left;
                    if (beats_left == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_DONE: begin
                // Hold here until the FSM drops valid so a lagging valid
                // cannot start the same descriptor again
                if (!dma_stream_rd_valid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort wins over everything; a same-cycle handshake is still
        // considered taken by the AXI side
        if (clear_dma_i) begin
            state_d             = ST_IDLE;
            addr_d              = '0;
            beats_d             = '0;
            len_d               = '0;
            done_d              = 1'b0;
            dma_stream_rd_err_o = '0;
        end
    end

    assign dma_stream_rd_done_o = done_q;
    assign rd_req_addr_o        = addr_q;
    assign rd_req_len_o         = len_q;
    assign rd_req_size_o        = 3'(BPB_LOG2);
    assign rd_busy_o            = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dma_rd_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dma_rd_streamer
//  Description : Directed self-checking bench for dma_rd_streamer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_rd_streamer;
    import dma_pkg::*;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         valid_i = 1'b0;
    s_dma_desc_t  desc = '0;
    logic         clear_i = 1'b0;
    logic         done_o;
    s_dma_error_t err_o;
    logic         req_valid;
    logic         req_ready = 1'b0;
    logic [31:0]  req_addr;
    logic [7:0]   req_len;
    logic [2:0]   req_size;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0]  hs_addr[$];
    logic [7:0]   hs_len[$];
    int           hs_cyc[$];
    int           done_cyc[$];
    s_dma_error_t err_q[$];
    int           err_cyc[$];

    dma_rd_streamer #(
        .ADDR_W(32), .DATA_W(64), .BYTES_W(32), .MAX_BEATS(16)
    ) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .dma_stream_rd_valid_i (valid_i),
        .dma_desc_i            (desc),
        .clear_dma_i           (clear_i),
        .dma_stream_rd_done_o  (done_o),
        .dma_stream_rd_err_o   (err_o),
        .rd_req_valid_o        (req_valid),
        .rd_req_ready_i        (req_ready),
        .rd_req_addr_o         (req_addr),
        .rd_req_len_o          (req_len),
        .rd_req_size_o         (req_size),
        .rd_busy_o             (busy)
    );

    always #5 clk = ~clk;

    // Event log: handshakes, done pulses and error pulses with their cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rstn) begin
            if (req_valid && req_ready) begin
                hs_addr.push_back(req_addr);
                hs_len.push_back(req_len);
                hs_cyc.push_back(cyc);
            end
            if (done_o) done_cyc.push_back(cyc);
            if (err_o.valid) begin
                err_q.push_back(err_o);
                err_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        hs_addr.delete(); hs_len.delete(); hs_cyc.delete();
        done_cyc.delete(); err_q.delete(); err_cyc.delete();
    endtask

    task automatic start_job(input logic [31:0] src, input logic [31:0] nb, output int t0);
        clear_logs();
        desc.src_addr  = src;
        desc.dst_addr  = 32'hDEAD_0000;
        desc.num_bytes = nb;
        valid_i = 1'b1;
        t0 = cyc;
    endtask

    // Holds valid until done is seen (bounded), then releases it
    task automatic finish_job(input string name);
        int n = 0;
        while (done_cyc.size() == 0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (done_cyc.size() == 0) begin
            errors++;
            $display("FAIL %s_done_timeout: no done after %0d cycles", name, n);
        end
        valid_i = 1'b0;
        desc    = '0;
        tick();
        tick();
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!req_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!req_valid) begin
            errors++;
            $display("FAIL %s_req_timeout: rd_req_valid_o never rose", name);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_valid, done_o, err_o.valid, busy, req_addr, req_len} !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {req_valid, done_o, err_o.valid, busy, req_addr, req_len});
        end
        checks++;
        if (req_size !== 3'd3) begin
            errors++;
            $display("FAIL reset_size: got %0d expected 3", req_size);
        end
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int t0;
        logic [31:0] ea[2] = '{32'h1000, 32'h1080};
        logic [7:0]  el[2] = '{8'd15, 8'd15};
        req_ready = 1'b1;
        start_job(32'h1000, 32'h100, t0);
        finish_job("basic");
        checks++;
        if (hs_addr.size() != 2) begin
            errors++;
            $display("FAIL basic_count: got %0d expected 2", hs_addr.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (hs_addr[i] !== ea[i] || hs_len[i] !== el[i]) begin
                    errors++;
                    $display("FAIL basic_req%0d: got %h/%0d expected %h/%0d",
                             i, hs_addr[i], hs_len[i], ea[i], el[i]);
                end
            end
            checks++;
            if (hs_cyc[0] - t0 != 2 || hs_cyc[1] - hs_cyc[0] != 2) begin
                errors++;
                $display("FAIL basic_latency: got %0d,%0d expected 2,2",
                         hs_cyc[0] - t0, hs_cyc[1] - hs_cyc[0]);
            end
            checks++;
            if (done_cyc.size() != 1 || done_cyc[0] - hs_cyc[1] != 1) begin
                errors++;
                $display("FAIL basic_done: got %0d pulses", done_cyc.size());
            end
        end
        checks++;
        if (err_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_err_busy: got errs=%0d busy=%b expected 0 0", err_q.size(), busy);
        end
    endtask

    task automatic test_4k();
        int t0;
        logic [31:0] src[2] = '{32'h0000_0FF0, 32'hFFFF_FF80};
        logic [31:0] nb[2]  = '{32'h40, 32'h100};
        logic [31:0] ea[4]  = '{32'h0FF0, 32'h1000, 32'hFFFF_FF80, 32'h0};
        logic [7:0]  el[4]  = '{8'd1, 8'd5, 8'd15, 8'd15};
        req_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            start_job(src[j], nb[j], t0);
            finish_job("k4");
            checks++;
            if (hs_addr.size() != 2) begin
                errors++;
                $display("FAIL k4_count%0d: got %0d expected 2", j, hs_addr.size());
            end else begin
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (hs_addr[i] !== ea[2*j+i] || hs_len[i] !== el[2*j+i]) begin
                        errors++;
                        $display("FAIL k4_req%0d_%0d: got %h/%0d expected %h/%0d",
                                 j, i, hs_addr[i], hs_len[i], ea[2*j+i], el[2*j+i]);
                    end
                end
            end
        end
    endtask

    task automatic test_misaligned();
        int t0;
        logic [31:0] src[2] = '{32'h1004, 32'h2000};
        logic [31:0] nb[2]  = '{32'h20, 32'h21};
        req_ready = 1'b1;
        for (int j = 0; j < 2; j++) begin
            start_job(src[j], nb[j], t0);
            #1;
            checks++;
            if (err_o.valid !== 1'b1 || err_o.src !== DMA_ERR_SRC_RD || err_o.addr !== src[j]) begin
                errors++;
                $display("FAIL misalign_err%0d: got %b/%b/%h expected 1/1/%h",
                         j, err_o.valid, err_o.src, err_o.addr, src[j]);
            end
            finish_job("misalign");
            checks++;
            if (err_q.size() != 1 || done_cyc.size() != 1 || hs_addr.size() != 0) begin
                errors++;
                $display("FAIL misalign_counts%0d: got err=%0d done=%0d req=%0d expected 1 1 0",
                         j, err_q.size(), done_cyc.size(), hs_addr.size());
            end else begin
                checks++;
                if (done_cyc[0] - err_cyc[0] != 1) begin
                    errors++;
                    $display("FAIL misalign_done_delay%0d: got %0d expected 1", j, done_cyc[0] - err_cyc[0]);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        int t0;
        start_job(32'h4000, 32'h0, t0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_hold_busy: got %b expected 1", busy);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] - t0 != 1) begin
            errors++;
            $display("FAIL zero_done: got %0d pulses expected 1 at +1", done_cyc.size());
        end
        checks++;
        if (hs_addr.size() != 0 || err_q.size() != 0) begin
            errors++;
            $display("FAIL zero_no_req_err: got req=%0d err=%0d expected 0 0", hs_addr.size(), err_q.size());
        end
        valid_i = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int t0;
        req_ready = 1'b0;
        start_job(32'h2000, 32'h40, t0);
        wait_req("bp");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (req_valid !== 1'b1 || req_addr !== 32'h2000 || req_len !== 8'd7) begin
                errors++;
                $display("FAIL bp_hold%0d: got %b/%h/%0d expected 1/00002000/7",
                         i, req_valid, req_addr, req_len);
            end
            tick();
        end
        req_ready = 1'b1;
        finish_job("bp");
        checks++;
        if (hs_addr.size() != 1 || done_cyc.size() != 1) begin
            errors++;
            $display("FAIL bp_count: got req=%0d done=%0d expected 1 1", hs_addr.size(), done_cyc.size());
        end
    endtask

    task automatic test_clear();
        int t0;
        logic [31:0] ea[3] = '{32'h3000, 32'h3080, 32'h3100};
        req_ready = 1'b0;
        start_job(32'h3000, 32'h180, t0);
        wait_req("clr");
        clear_i = 1'b1;
        tick();
        checks++;
        if (req_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_drop: got valid=%b busy=%b expected 0 0", req_valid, busy);
        end
        clear_i = 1'b0;
        valid_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (done_cyc.size() != 0 || hs_addr.size() != 0) begin
            errors++;
            $display("FAIL clr_quiet: got done=%0d req=%0d expected 0 0", done_cyc.size(), hs_addr.size());
        end
        req_ready = 1'b1;
        start_job(32'h3000, 32'h180, t0);
        finish_job("clr_rerun");
        checks++;
        if (hs_addr.size() != 3) begin
            errors++;
            $display("FAIL clr_rerun_count: got %0d expected 3", hs_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hs_addr[i] !== ea[i] || hs_len[i] !== 8'd15) begin
                    errors++;
                    $display("FAIL clr_rerun_req%0d: got %h/%0d expected %h/15",
                             i, hs_addr[i], hs_len[i], ea[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int t0;
        req_ready = 1'b0;
        start_job(32'h5000, 32'h100, t0);
        wait_req("rst");
        rstn    = 1'b0;
        valid_i = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b0 || busy !== 1'b0 || req_addr !== 32'h0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got valid=%b busy=%b addr=%h done=%b expected 0 0 0 0",
                     req_valid, busy, req_addr, done_o);
        end
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (done_cyc.size() != 0 || err_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_quiet: got done=%0d err=%0d busy=%b expected 0 0 0",
                     done_cyc.size(), err_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_4k();
        test_misaligned();
        test_zero_len();
        test_backpressure();
        test_clear();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
